seg7_bcd_reader: RTL
====================

Name: seg7_bcd_reader

Overview:
- Inverse of the BCD-to-7-segment decoder family.
- Watches a multiplexed 7-segment display bus: active-low segment lines plus one-hot digit strobes.
- Qualifies each digit's pattern for stability and decodes it back to a 4-bit code with blank and error flags.
- Streams one complete frame of digits out over a valid/ready handshake. Used by benches and display-readback logic that must recover the numeric value a decoder chip is driving.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (2..8).
- STABLE, 3, consecutive identical samples required to capture a digit (1..15).
- IW, $clog2(DIGITS), width of the digit index (derived; minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- seg  input  7  active-low segment pattern, seg[6]=a … seg[0]=g (0 = lit).
- dig  input  DIGITS  one-hot digit strobe, dig[0] = least significant digit.
- bcd  output  4  decoded code of the emitted digit.
- blank  output  1  emitted digit was dark.
- err  output  1  emitted digit's pattern is not in the decode table.
- idx  output  IW  position of the emitted digit.
- valid  output  1  bcd/blank/err/idx are valid.
- ready  input  1  consumer accepts on valid&&ready.
- frame  output  1  one-cycle pulse after the last digit of a frame is accepted.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - valid=0, frame=0, bcd=0, blank=0, err=0, idx=0.
  - All slot-filled bits=0, stability counter=0, armed=1, FSM=SCAN.
  - Reset mid-frame discards all slots and any pending output.
- Sampling, every clk in SCAN:
  - If dig is exactly one-hot and (dig,seg) equals the previous cycle's (dig,seg), the counter increments, saturating at STABLE. Otherwise the counter loads 1 (one-hot) or 0 (zero/multi-hot).
  - Capture occurs on the edge where the counter reaches STABLE and armed=1. The decoded result is written to slot[i] for dig[i]=1, the filled[i] bit is set, and armed is cleared.
  - armed is set again whenever dig changes.
  - With STABLE=1, capture happens on the first one-hot sample.
- Decode table (seg → bcd):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4.
  - 0100100→5, 1100000→6, 0001111→7, 0000000→8 (lamp test is indistinguishable from 8).
  - 0001100→9, 1110010→10, 1100110→11, 1011100→12, 0110100→13, 1110000→14.
  - 1111111 → bcd=15, blank=1.
  - Any other pattern → bcd=15, err=1.
- Recapture of an already-filled slot while in SCAN overwrites it.
- FSM SCAN→EMIT: on the clock edge where filled becomes all-ones, including when the final capture happens that same edge. valid rises the following cycle with idx=0.
- EMIT:
  - Presents slots idx=0..DIGITS-1 in order.
  - Outputs are held stable while valid=1 && ready=0.
  - On valid&&ready, idx advances the next cycle, with no bubble between digits.
  - ready while valid=0 has no effect.
  - Captures are suppressed in EMIT; the counter keeps tracking.
- EMIT→SCAN: after acceptance of idx=DIGITS-1.
  - valid drops, frame=1 for exactly one cycle, filled clears, armed=1.
- Output registers retain their last values when valid=0.

Optional Feature:
- Macro SEG7RD_LEADZERO_EN.
- Defined: a contiguous run of blank digits from idx DIGITS-1 downward, stopping at the first non-blank digit and never including idx 0, is emitted as bcd=0, blank=1. This reconstructs ripple-blanked leading zeros. Blank digits outside that run are emitted as bcd=15.
- Undefined: every blank digit is emitted as bcd=15, blank=1.
- err digits are never treated as blank.

Decomposition:
- Shared package: 7-bit segment-pattern constants for codes 0–14 and BLANK, the FSM state encoding (SCAN, EMIT), and the pattern→{bcd,blank,err} decode function.
- One natural sub-module: seg7_pattern_decode, a combinational 7→6-bit decoder reused per capture.

Test Plan:
- Reset: clr_n=0 during EMIT with valid=1 → valid=0, idx=0, frame=0 immediately. After release, a full frame must be rescanned.
- Basic frame: DIGITS=4, STABLE=3, drive 3 clocks each of dig=0001/seg=0000110, 0010/1001111, 0100/0000001, 1000/1111111 with ready=1. Expected:
  - idx0 bcd=3.
  - idx1 bcd=1.
  - idx2 bcd=0.
  - idx3 bcd=15 blank=1.
  - One frame pulse.
- Stability: dig=0001 with seg toggling 0000110/0000111 every 2 clocks → no capture, valid stays 0. Then 3 steady clocks of 0000110 → slot0 captured.
- Backpressure: ready=0 for 5 cycles after valid → bcd/idx held constant. ready=1 → four consecutive accepts, then frame=1 for one cycle.
- Error/multi-hot: seg=1010101 on digit 2 → emitted err=1, bcd=15. dig=0011 for 10 cycles → no capture.
- With SEG7RD_LEADZERO_EN: digits idx3..0 = blank, blank, 5, blank → idx3/idx2 emitted bcd=0 blank=1, idx1 bcd=5, idx0 bcd=15 blank=1.

Source files
------------

// File: rtl/seg7_bcd_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_bcd_reader_pkg                                             |
// | Purpose  : Shared definitions for the 7-segment readback block:            |
// |            active-low segment patterns (seg[6]=a .. seg[0]=g, 0 = lit),    |
// |            FSM state encoding and the pattern -> {bcd,blank,err} decode.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package seg7_bcd_reader_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b1100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_10    = 7'b1110010;
   localparam logic [6:0] SEG_11    = 7'b1100110;
   localparam logic [6:0] SEG_12    = 7'b1011100;
   localparam logic [6:0] SEG_13    = 7'b0110100;
   localparam logic [6:0] SEG_14    = 7'b1110000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [0:0] {
      SCAN = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Decoded digit as held in a capture slot.
   typedef struct packed {
      logic [3:0] bcd;
      logic       blank;
      logic       err;
   } dec_t;

   // Lamp test (all lit) reads back as 8; it cannot be told apart.
   function automatic dec_t seg7_decode(input logic [6:0] seg);
      dec_t d;
      d.bcd   = 4'd15;
      d.blank = 1'b0;
      d.err   = 1'b0;
      case (seg)
         SEG_0:     d.bcd = 4'd0;
         SEG_1:     d.bcd = 4'd1;
         SEG_2:     d.bcd = 4'd2;
         SEG_3:     d.bcd = 4'd3;
         SEG_4:     d.bcd = 4'd4;
         SEG_5:     d.bcd = 4'd5;
         SEG_6:     d.bcd = 4'd6;
         SEG_7:     d.bcd = 4'd7;
         SEG_8:     d.bcd = 4'd8;
         SEG_9:     d.bcd = 4'd9;
         SEG_10:    d.bcd = 4'd10;
         SEG_11:    d.bcd = 4'd11;
         SEG_12:    d.bcd = 4'd12;
         SEG_13:    d.bcd = 4'd13;
         SEG_14:    d.bcd = 4'd14;
         SEG_BLANK: d.blank = 1'b1;
         default:   d.err = 1'b1;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_pattern_decode                                             |
// | Purpose  : Combinational 7-segment pattern -> 4-bit code decoder.          |
// | Ports    : seg_i   [6:0] active-low segment pattern                        |
// |            bcd_o   [3:0] decoded code (15 for blank / unknown)             |
// |            blank_o       pattern is fully dark                             |
// |            err_o         pattern is not in the decode table                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_pattern_decode
   import seg7_bcd_reader_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       blank_o,
   output logic       err_o
);

   dec_t w_dec;

   assign w_dec   = seg7_decode(seg_i);
   assign bcd_o   = w_dec.bcd;
   assign blank_o = w_dec.blank;
   assign err_o   = w_dec.err;

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_bcd_reader                                                 |
// | Purpose  : Watches a multiplexed 7-segment bus, captures each digit once   |
// |            its pattern is stable, decodes it and streams a full frame of   |
// |            digits out over valid/ready.                                    |
// | Ports    : clk            rising-edge clock                                |
// |            clr_n          asynchronous active-low reset                    |
// |            seg   [6:0]    active-low segments, seg[6]=a .. seg[0]=g        |
// |            dig   [D-1:0]  one-hot digit strobe, dig[0] = LS digit          |
// |            bcd   [3:0]    emitted digit code                               |
// |            blank          emitted digit was dark                           |
// |            err            emitted pattern not in decode table              |
// |            idx   [IW-1:0] emitted digit position                           |
// |            valid / ready  output handshake                                 |
// |            frame          pulse after last digit of a frame is accepted    |
// | Options  : SEG7RD_LEADZERO_EN - emit leading blank run as bcd=0            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_bcd_reader
   import seg7_bcd_reader_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int STABLE = 3,
   parameter int IW     = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [6:0]        seg,
   input  logic [DIGITS-1:0] dig,
   output logic [3:0]        bcd,
   output logic              blank,
   output logic              err,
   output logic [IW-1:0]     idx,
   output logic              valid,
   input  logic              ready,
   output logic              frame
);

   localparam logic [3:0]    STABLE_C = 4'(STABLE);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   // Sampling / capture state
   logic [DIGITS-1:0] dig_prev_q;
   logic [6:0]        seg_prev_q;
   logic [3:0]        cnt_q, cnt_d;
   logic              armed_q, armed_d;
   dec_t              slot_q [DIGITS];
   dec_t              slot_d [DIGITS];
   logic [DIGITS-1:0] filled_q, filled_d;

   // FSM and registered outputs
   state_e            state_q;
   logic [3:0]        bcd_q;
   logic              blank_q;
   logic              err_q;
   logic [IW-1:0]     idx_q;
   logic              valid_q;
   logic              frame_q;

   logic [3:0]        w_dec_bcd;
   logic              w_dec_blank;
   logic              w_dec_err;
   dec_t              w_dec;
   logic              w_same;
   logic              w_armed;
   logic              w_capture;
   logic              w_accept;
   logic              w_exit;
   logic              w_to_emit;
   logic [IW-1:0]     w_next_idx;
   dec_t              w_next_slot;
   logic [DIGITS-1:0] w_lz;

   seg7_pattern_decode u_decode (
      .seg_i   (seg),
      .bcd_o   (w_dec_bcd),
      .blank_o (w_dec_blank),
      .err_o   (w_dec_err)
   );

   assign w_dec = {w_dec_bcd, w_dec_blank, w_dec_err};

   assign w_accept   = (state_q == EMIT) && valid_q && ready;
   assign w_exit     = w_accept && (idx_q == LAST_IDX);
   assign w_next_idx = idx_q + IW'(1);
   assign w_next_slot = slot_q[w_next_idx];

   // Stability counter and arming.  A digit change re-arms in the same cycle
   // so that STABLE=1 can capture on the very first sample of a new digit.
   always_comb begin
      w_same = (dig == dig_prev_q) && (seg == seg_prev_q);
      cnt_d  = 4'd0;
      if ($onehot(dig)) begin
         if (!w_same) begin
            cnt_d = 4'd1;
         end else if (cnt_q == STABLE_C) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
      w_armed   = armed_q | (dig != dig_prev_q);
      w_capture = (state_q == SCAN) && w_armed && (cnt_d == STABLE_C);
      armed_d   = w_armed & ~w_capture;
      if (w_exit) begin
         armed_d = 1'b1;
      end
   end

   // Slot write and fill tracking; filled_d is used so that the capture which
   // completes a frame also triggers the move to EMIT on the same edge.
   always_comb begin
      filled_d = filled_q;
      for (int i = 0; i < DIGITS; i++) begin
         slot_d[i] = slot_q[i];
         if (w_capture && dig[i]) begin
            slot_d[i]   = w_dec;
            filled_d[i] = 1'b1;
         end
      end
      if (w_exit) begin
         filled_d = '0;
      end
   end

   assign w_to_emit = (state_q == SCAN) && (&filled_d);

`ifdef SEG7RD_LEADZERO_EN
   // Blank run from the top digit downward; idx 0 is never part of it.
   logic w_lz_run;
   always_comb begin
      w_lz     = '0;
      w_lz_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_lz_run = w_lz_run & slot_q[i].blank;
         w_lz[i]  = w_lz_run;
      end
   end
`else
   assign w_lz = '0;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         dig_prev_q <= '0;
         seg_prev_q <= '0;
         cnt_q      <= 4'd0;
         armed_q    <= 1'b1;
         filled_q   <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         dig_prev_q <= dig;
         seg_prev_q <= seg;
         cnt_q      <= cnt_d;
         armed_q    <= armed_d;
         filled_q   <= filled_d;
         for (int i = 0; i < DIGITS; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // Frame FSM with registered outputs.  Slot 0 is taken from slot_d because
   // it may be written on the same edge that completes the frame.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= SCAN;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
         bcd_q   <= 4'd0;
         blank_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         frame_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (w_to_emit) begin
                  state_q <= EMIT;
                  valid_q <= 1'b1;
                  idx_q   <= '0;
                  bcd_q   <= slot_d[0].bcd;
                  blank_q <= slot_d[0].blank;
                  err_q   <= slot_d[0].err;
               end
            end
            EMIT: begin
               if (w_accept) begin
                  if (w_exit) begin
                     state_q <= SCAN;
                     valid_q <= 1'b0;
                     frame_q <= 1'b1;
                  end else begin
                     idx_q   <= w_next_idx;
                     bcd_q   <= w_lz[w_next_idx] ? 4'd0 : w_next_slot.bcd;
                     blank_q <= w_next_slot.blank;
                     err_q   <= w_next_slot.err;
                  end
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign bcd   = bcd_q;
   assign blank = blank_q;
   assign err   = err_q;
   assign idx   = idx_q;
   assign valid = valid_q;
   assign frame = frame_q;

endmodule
`default_nettype wire
